// File: rtl/vga_display_engine.sv
// Parametrised VGA raster engine: graphics (12-bit RGB) or 8x16 text with attributes and blinking cursor.
// Counter position reaches the pins after VRAM_LAT+FONT_LAT+1 clocks in either mode.
module vga_display_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b0,
    parameter int VRAM_LAT     = 1,
    parameter int FONT_LAT     = 1,
    parameter int ADDR_W       = 19,
    parameter int BLINK_LOG2   = 5,
    parameter int CURSOR_LINES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_req,
    input  logic [11:0]       forecolor,
    input  logic [11:0]       backcolor,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_col,
    input  logic [4:0]        cursor_row,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [11:0]       vram_data,
    output logic [14:0]       font_addr,
    input  logic              font_bit,
    output logic              frame_start,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B
);
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(HT);
    localparam int VW       = $clog2(VT);
    localparam int D        = VRAM_LAT + FONT_LAT;
    localparam int FCW      = BLINK_LOG2 + 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       gfx;
        logic       blink_on;
        logic       cur_hit;
        logic [3:0] prow;
        logic [2:0] pcol;
    } side_t;

    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic [FCW-1:0] frame_cnt;
    logic [FCW-1:0] frame_eff;
    logic           mode;
    logic           mode_eff;
    side_t          s0;
    side_t          so;
    side_t          side_q [1:D];
    logic [11:0]    dat_q [1:FONT_LAT];
    logic [11:0]    attr;
    logic [11:0]    fg;
    logic [11:0]    bg;
    logic [11:0]    pix;
    logic           fg_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == HW'(HT - 1)) begin
            h <= '0;
            v <= (v == VW'(VT - 1)) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    assign frame_start = ~rst & (h == '0) & (v == '0);

    // Mode and blink phase take effect on the frame_start pixel itself, not one clock later.
    assign mode_eff  = frame_start ? mode_req : mode;
    assign frame_eff = frame_start ? frame_cnt + FCW'(1) : frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            mode      <= mode_eff;
            frame_cnt <= frame_eff;
        end
    end

    assign vram_addr = mode_eff ? ADDR_W'(32'(v) * 32'(H_ACTIVE) + 32'(h))
                                : ADDR_W'(32'(v >> 4) * 32'(H_ACTIVE / 8) + 32'(h >> 3));

    always_comb begin
        s0          = '0;
        s0.active   = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        s0.hs       = (32'(h) >= HS_START) && (32'(h) < HS_END);
        s0.vs       = (32'(v) >= VS_START) && (32'(v) < VS_END);
        s0.gfx      = mode_eff;
        s0.blink_on = frame_eff[BLINK_LOG2];
        s0.cur_hit  = cursor_en && (32'(h >> 3) == 32'(cursor_col)) && (32'(v >> 4) == 32'(cursor_row))
                      && (v[3:0] >= 4'(16 - CURSOR_LINES));
        s0.prow     = v[3:0];
        s0.pcol     = h[2:0];
    end

    // Side info rides alongside the fetches; vram_data is held FONT_LAT more clocks to meet font_bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= D; i++) side_q[i] <= '0;
            for (int i = 1; i <= FONT_LAT; i++) dat_q[i] <= '0;
        end else begin
            side_q[1] <= s0;
            for (int i = 2; i <= D; i++) side_q[i] <= side_q[i-1];
            dat_q[1] <= vram_data;
            for (int i = 2; i <= FONT_LAT; i++) dat_q[i] <= dat_q[i-1];
        end
    end

    assign font_addr = {vram_data[7:0], side_q[VRAM_LAT].prow, side_q[VRAM_LAT].pcol};
    assign so        = side_q[D];
    assign attr      = dat_q[FONT_LAT];

    always_comb begin
        fg     = forecolor;
        bg     = backcolor;
        fg_sel = 1'b0;
        pix    = '0;
        if (attr[8]) begin
            fg = backcolor;
            bg = forecolor;
        end
        fg_sel = font_bit & ~(attr[9] & ~so.blink_on);
        fg_sel = fg_sel ^ (so.cur_hit & so.blink_on);
        if (so.active) pix = so.gfx ? attr : (fg_sel ? fg : bg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            VGA_HS <= ~SYNC_POL;
            VGA_VS <= ~SYNC_POL;
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
        end else begin
            VGA_HS <= so.hs ? SYNC_POL : ~SYNC_POL;
            VGA_VS <= so.vs ? SYNC_POL : ~SYNC_POL;
            VGA_R  <= pix[11:8];
            VGA_G  <= pix[7:4];
            VGA_B  <= pix[3:0];
        end
    end
endmodule

// File: tb/tb_vga_display_engine.sv
// Bench for vga_display_engine on a small raster with random VRAM/font contents and frame-level mode changes.
module tb_vga_display_engine;
    localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
    localparam int VA = 48, VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int VL = 2, FL = 2, L = VL + FL + 1;
    localparam int AW = 11, BL = 0, CL = 2;
    localparam bit SP = 1'b0;
    localparam int NCYC = 6 * FRAME + 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode_req = 1'b0;
    logic [11:0]   fc, bc;
    logic          cen = 1'b1;
    logic [6:0]    ccol = 7'd2;
    logic [4:0]    crow = 5'd2;
    logic [AW-1:0] vram_addr;
    logic [11:0]   vram_data;
    logic [14:0]   font_addr;
    logic          font_bit;
    logic          frame_start;
    logic          VGA_HS, VGA_VS;
    logic [3:0]    VGA_R, VGA_G, VGA_B;
    logic [13:0]   pins;

    logic [11:0]   vmem [2048];
    logic          font_tab [32768];
    logic [AW-1:0] a_q [VL];
    logic [14:0]   f_q [FL];
    bit            fmode [8];
    int            sched [8] = '{0, 1, 1, 0, 0, 1, 0, 0};
    int            checks = 0;
    int            errors = 0;

    vga_display_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_POL(SP), .VRAM_LAT(VL), .FONT_LAT(FL), .ADDR_W(AW),
        .BLINK_LOG2(BL), .CURSOR_LINES(CL)
    ) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req),
        .forecolor(fc), .backcolor(bc),
        .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow),
        .vram_addr(vram_addr), .vram_data(vram_data),
        .font_addr(font_addr), .font_bit(font_bit),
        .frame_start(frame_start),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 clk = ~clk;

    assign pins = {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};

    // Memories with fixed read latency.
    always @(posedge clk) begin
        a_q[0] <= vram_addr;
        for (int i = 1; i < VL; i++) a_q[i] <= a_q[i-1];
        f_q[0] <= font_addr;
        for (int i = 1; i < FL; i++) f_q[i] <= f_q[i-1];
    end
    assign vram_data = vmem[a_q[VL-1]];
    assign font_bit  = font_tab[f_q[FL-1]];

    task automatic check(input string tag, input int n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, got, exp);
        end
    endtask

    function automatic int addr_of(input int h, input int v, input bit gfx);
        int a;
        a = gfx ? v * HA + h : (v / 16) * (HA / 8) + h / 8;
        return a % (1 << AW);
    endfunction

    // Pin state expected during cycle n after reset release (pixel at position n-L).
    function automatic logic [13:0] exp_pins(input int n);
        int p, h, v, f;
        logic hs, vs, bon, fg_on;
        logic [11:0] rgb, d, fg, bg;
        if (n < L) return {~SP, ~SP, 12'h000};
        p = n - L;
        h = p % HT;
        v = (p / HT) % VT;
        f = p / FRAME;
        hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? SP : ~SP;
        vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? SP : ~SP;
        rgb = 12'h000;
        if (h < HA && v < VA) begin
            d = vmem[addr_of(h, v, fmode[f])];
            if (fmode[f]) begin
                rgb = d;
            end else begin
                bon   = (((f + 1) >> BL) & 1) == 1;
                fg    = d[8] ? bc : fc;
                bg    = d[8] ? fc : bc;
                fg_on = font_tab[{d[7:0], 4'(v % 16), 3'(h % 8)}];
                if (d[9] && !bon) fg_on = 1'b0;
                if (cen && h / 8 == int'(ccol) && v / 16 == int'(crow) && v % 16 >= 16 - CL && bon)
                    fg_on = !fg_on;
                rgb = fg_on ? fg : bg;
            end
        end
        return {hs, vs, rgb};
    endfunction

    initial begin
        int hh, vv, ff, pp;
        logic [11:0] dd;
        for (int i = 0; i < 2048; i++) vmem[i] = 12'($urandom);
        for (int i = 0; i < 32768; i++) font_tab[i] = 1'($urandom);
        fc = 12'($urandom);
        bc = 12'($urandom);
        if (bc == fc) bc = ~fc;

        repeat (4) @(negedge clk);
        #1;
        check("rst_pins", -1, 32'(pins), 32'({~SP, ~SP, 12'h000}));
        check("rst_addr", -1, 32'(vram_addr), 32'd0);
        check("rst_fs", -1, 32'(frame_start), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < NCYC; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            hh = n % HT;
            vv = (n / HT) % VT;
            ff = n / FRAME;
            if (hh == 0 && vv == 0) fmode[ff] = mode_req;
            check("frame_start", n, 32'(frame_start), 32'((hh == 0 && vv == 0) ? 1 : 0));
            check("vram_addr", n, 32'(vram_addr), 32'(addr_of(hh, vv, fmode[ff])));
            if (n >= VL) begin
                pp = n - VL;
                dd = vmem[addr_of(pp % HT, (pp / HT) % VT, fmode[pp / FRAME])];
                check("font_addr", n, 32'(font_addr),
                      32'({dd[7:0], 4'(((pp / HT) % VT) % 16), 3'((pp % HT) % 8)}));
            end
            check("pins", n, 32'(pins), 32'(exp_pins(n)));
            // Wiggle mode_req mid-frame; only its value at frame start may matter.
            if (hh == 0 && vv == 20) mode_req = sched[ff + 1][0];
            if (hh == 0 && vv == 30) mode_req = ~sched[ff + 1][0];
            if (hh == 0 && vv == 40) mode_req = sched[ff + 1][0];
        end

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_pins", -2, 32'(pins), 32'({~SP, ~SP, 12'h000}));
        check("midrst_addr", -2, 32'(vram_addr), 32'd0);
        check("midrst_fs", -2, 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rerel_fs0", 0, 32'(frame_start), 32'd1);
        check("rerel_addr0", 0, 32'(vram_addr), 32'd0);
        @(negedge clk);
        #1;
        check("rerel_fs1", 1, 32'(frame_start), 32'd0);
        check("rerel_addr1", 1, 32'(vram_addr), 32'(addr_of(1, 0, mode_req)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
